// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: stall/jump encodings,
// bus widths and the fetch FSM state encoding.
`timescale 1ns/1ps
package if_fetch_pkg;
  localparam int STALL_W     = 6;
  localparam int IF_BIT      = 1;
  localparam logic Stop      = 1'b1;
  localparam logic Continue  = 1'b0;
  localparam logic Jump      = 1'b1;
  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;
  localparam logic [InstBus-1:0] ZeroWord = '0;

  typedef enum logic {
    FETCH = 1'b0,
    BLOCK = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/if_fetch_byte_asm.sv
// Byte counter and 24-bit little-endian assembly buffer for bytes 0..2 of
// the instruction in flight; byte 3 goes straight to the output slot.
`timescale 1ns/1ps
module if_byte_asm
  import if_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  rdata,
  output logic [1:0]  byte_cnt,
  output logic [23:0] asm_buf,
  output logic        last,
  output logic        complete
);

  assign last     = (byte_cnt == 2'd3);
  assign complete = load & last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt <= 2'd0;
      asm_buf  <= 24'd0;
    end else if (clear) begin
      byte_cnt <= 2'd0;
      asm_buf  <= 24'd0;
    end else if (load) begin
      byte_cnt <= byte_cnt + 2'd1;
      case (byte_cnt)
        2'd0:    asm_buf[7:0]   <= rdata;
        2'd1:    asm_buf[15:8]  <= rdata;
        2'd2:    asm_buf[23:16] <= rdata;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC generation, byte-serial instruction fetch and
// a single-entry output slot feeding the IF/ID register.
`timescale 1ns/1ps
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [InstAddrBus-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STALL_W-1:0]     stall,
  input  logic                   jump_i,
  input  logic [InstAddrBus-1:0] jump_target_i,
  output logic                   mem_req_o,
  output logic [InstAddrBus-1:0] mem_addr_o,
  input  logic                   mem_ack_i,
  input  logic [7:0]             mem_rdata_i,
  output logic [InstAddrBus-1:0] if_pc,
  output logic [InstBus-1:0]     if_inst,
  output logic                   if_valid
);

  fetch_state_e             state_p0, state_d;
  logic [InstAddrBus-1:0]   pc_p0;
  logic [1:0]               byte_cnt;
  logic [23:0]              asm_buf;
  logic                     last, complete;
  logic                     consume, slot_free, take;
  logic                     unused_inputs;

  assign unused_inputs = ^{stall[STALL_W-1:IF_BIT+1], stall[IF_BIT-1:0],
                           jump_target_i[1:0]};

  always_comb begin
    consume   = if_valid & (stall[IF_BIT] != Stop) & (jump_i != Jump);
    slot_free = ~if_valid | consume;
    // Byte 3 is held back until the slot can take the finished word.
    mem_req_o = rst & (state_p0 == FETCH) & (jump_i != Jump) & ~(last & ~slot_free);
    mem_addr_o = pc_p0 + {30'd0, byte_cnt};
    take       = mem_req_o & mem_ack_i;
  end

  always_comb begin
    state_d = state_p0;
    if (jump_i == Jump) begin
      state_d = FETCH;
    end else begin
      case (state_p0)
        FETCH:   if (last & ~slot_free) state_d = BLOCK;
        BLOCK:   if (slot_free)         state_d = FETCH;
        default: state_d = FETCH;
      endcase
    end
  end

  if_byte_asm u_byte_asm (
    .clk      (clk),
    .rst      (rst),
    .clear    (jump_i),
    .load     (take),
    .rdata    (mem_rdata_i),
    .byte_cnt (byte_cnt),
    .asm_buf  (asm_buf),
    .last     (last),
    .complete (complete)
  );

  // Fetch PC and FSM state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_p0 <= FETCH;
      pc_p0    <= RESET_PC;
    end else begin
      state_p0 <= state_d;
      if (jump_i == Jump)
        pc_p0 <= {jump_target_i[InstAddrBus-1:2], 2'b00};
      else if (complete)
        pc_p0 <= pc_p0 + 32'd4;
    end
  end

  // Output slot toward IF/ID
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_inst  <= ZeroWord;
    end else if (jump_i == Jump) begin
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_inst  <= ZeroWord;
    end else if (complete) begin
      if_valid <= 1'b1;
      if_pc    <= pc_p0;
      if_inst  <= {mem_rdata_i, asm_buf};
    end else if (consume) begin
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_inst  <= ZeroWord;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: byte memory with programmable wait states, a
// table of reset/latency vectors, directed corner sequences and a random run.
`timescale 1ns/1ps
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        jump_i;
  logic [31:0] jump_target_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [7:0]  mem_rdata_i;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .jump_i        (jump_i),
    .jump_target_i (jump_target_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_ack_i     (mem_ack_i),
    .mem_rdata_i   (mem_rdata_i),
    .if_pc         (if_pc),
    .if_inst       (if_inst),
    .if_valid      (if_valid)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'd0:   return 8'h13;
      32'd1:   return 8'h00;
      32'd2:   return 8'h50;
      32'd3:   return 8'h00;
      default: return a[7:0] ^ a[15:8] ^ 8'hA5;
    endcase
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  // stimulus requested for the next cycle
  logic        stall_v, jump_v, force_ack;
  logic [31:0] jt_v;
  int          wait_v;
  bit          rand_wait;
  // memory bookkeeping
  logic        req_prev, ack_prev;
  logic [31:0] addr_prev;
  int          wcnt;
  // reference model: next fetch address, bytes accepted, last-cycle facts
  logic [31:0] m_fetch_pc;
  int          m_nacks;
  logic        p_jump, p_complete, p_valid, p_consume;
  logic [31:0] p_pc, p_inst, p_present_pc;
  logic        new_inst;

  task automatic cycle();
    @(negedge clk);
    stall         = {4'b0, stall_v, 1'b0};
    jump_i        = jump_v;
    jump_target_i = jt_v;
    #1;
    if (mem_req_o) begin
      if (req_prev && mem_addr_o == addr_prev && !ack_prev) wcnt++;
      else wcnt = 0;
      mem_ack_i = (wcnt >= wait_v);
    end else begin
      wcnt      = 0;
      mem_ack_i = force_ack;
    end
    mem_rdata_i = (mem_ack_i && mem_req_o) ? mem_byte(mem_addr_o) : 8'($urandom);
    #1;
    new_inst = 1'b0;
    if (p_jump) begin
      check("jump_bubble", {31'd0, if_valid}, 32'd0);
    end else if (p_complete) begin
      check("new_valid", {31'd0, if_valid}, 32'd1);
      check("new_pc", if_pc, p_present_pc);
      check("new_inst", if_inst, mem_word(p_present_pc));
      new_inst = 1'b1;
    end else if (p_valid && !p_consume) begin
      check("hold_valid", {31'd0, if_valid}, 32'd1);
      check("hold_pc", if_pc, p_pc);
      check("hold_inst", if_inst, p_inst);
    end else begin
      check("consumed_valid", {31'd0, if_valid}, 32'd0);
    end
    if (!if_valid) check("bubble_zero", if_pc | if_inst, 32'd0);
    if (mem_req_o) check("req_addr", mem_addr_o, m_fetch_pc + 32'(m_nacks));
    if (m_nacks == 3 && if_valid && stall[1] && !jump_i)
      check("byte3_held", {31'd0, mem_req_o}, 32'd0);
    // advance the model across the coming rising edge
    p_jump     = jump_i;
    p_valid    = if_valid;
    p_consume  = if_valid && !stall[1] && !jump_i;
    p_pc       = if_pc;
    p_inst     = if_inst;
    p_complete = 1'b0;
    if (jump_i) begin
      m_fetch_pc = {jump_target_i[31:2], 2'b00};
      m_nacks    = 0;
    end else if (mem_req_o && mem_ack_i) begin
      if (m_nacks == 3) begin
        p_complete   = 1'b1;
        p_present_pc = m_fetch_pc;
        m_fetch_pc   = m_fetch_pc + 32'd4;
        m_nacks      = 0;
      end else begin
        m_nacks++;
      end
    end
    req_prev  = mem_req_o;
    addr_prev = mem_addr_o;
    ack_prev  = mem_ack_i;
    if (rand_wait && mem_ack_i) wait_v = $urandom_range(0, 3);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    stall_v = 1'b0; jump_v = 1'b0; force_ack = 1'b0; jt_v = 32'd0;
    stall = 6'd0; jump_i = 1'b0; jump_target_i = 32'd0;
    mem_ack_i = 1'b0; mem_rdata_i = 8'd0;
    m_fetch_pc = 32'd0; m_nacks = 0;
    p_jump = 0; p_complete = 0; p_valid = 0; p_consume = 0;
    p_pc = 0; p_inst = 0; p_present_pc = 0;
    req_prev = 0; ack_prev = 0; addr_prev = 0; wcnt = 0;
    #1;
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_outs", if_pc | if_inst, 32'd0);
    check("rst_req", {31'd0, mem_req_o}, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  task automatic run_until_new(input int maxc, output logic [31:0] pc);
    pc = 32'hDEAD_BEEF;
    for (int i = 0; i < maxc; i++) begin
      cycle();
      if (new_inst) begin
        pc = if_pc;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL timeout: no instruction within %0d cycles", maxc);
  endtask

  typedef struct {
    logic        stall;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] pc_seen;
    int          first, second;
    int          ninst;

    tbl[0] = '{1'b0, 1'b1, 32'd0, 1'b0, 32'd0, 32'd0};
    tbl[1] = '{1'b0, 1'b1, 32'd1, 1'b0, 32'd0, 32'd0};
    tbl[2] = '{1'b0, 1'b1, 32'd2, 1'b0, 32'd0, 32'd0};
    tbl[3] = '{1'b0, 1'b1, 32'd3, 1'b0, 32'd0, 32'd0};
    tbl[4] = '{1'b0, 1'b1, 32'd4, 1'b1, 32'd0, 32'h0050_0013};
    tbl[5] = '{1'b0, 1'b1, 32'd5, 1'b0, 32'd0, 32'd0};
    tbl[6] = '{1'b0, 1'b1, 32'd6, 1'b0, 32'd0, 32'd0};
    tbl[7] = '{1'b0, 1'b1, 32'd7, 1'b0, 32'd0, 32'd0};
    tbl[8] = '{1'b0, 1'b1, 32'd8, 1'b1, 32'd4, 32'hA2A3_A0A1};

    rand_wait = 0;
    wait_v    = 0;
    do_reset();

    // zero-wait fetch from reset, cycle by cycle
    for (int i = 0; i < 9; i++) begin
      stall_v = tbl[i].stall;
      jump_v  = 1'b0;
      cycle();
      check($sformatf("tbl%0d_req", i + 1), {31'd0, mem_req_o}, {31'd0, tbl[i].req});
      check($sformatf("tbl%0d_addr", i + 1), mem_addr_o, tbl[i].addr);
      check($sformatf("tbl%0d_valid", i + 1), {31'd0, if_valid}, {31'd0, tbl[i].valid});
      check($sformatf("tbl%0d_pc", i + 1), if_pc, tbl[i].pc);
      check($sformatf("tbl%0d_inst", i + 1), if_inst, tbl[i].inst);
    end

    // asynchronous reset while fetching pc=8 with an instruction presented
    do_reset();
    cycle();
    check("post_rst_addr", mem_addr_o, 32'd0);
    check("post_rst_req", {31'd0, mem_req_o}, 32'd1);

    // two wait states per byte
    do_reset();
    wait_v = 2;
    first = 0; second = 0;
    for (int c = 1; c <= 40; c++) begin
      cycle();
      if (new_inst) begin
        if (first == 0) first = c;
        else begin
          second = c;
          break;
        end
      end
    end
    check("wait2_first_cycle", 32'(first), 32'd13);
    check("wait2_second_cycle", 32'(second), 32'd25);

    // stall with an instruction held, then release
    wait_v = 0;
    do_reset();
    for (int i = 0; i < 4; i++) cycle();
    stall_v = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    check("stall_req_off", {31'd0, mem_req_o}, 32'd0);
    check("stall_pc", if_pc, 32'd0);
    check("stall_inst", if_inst, 32'h0050_0013);
    stall_v = 1'b0;
    run_until_new(6, pc_seen);
    check("stall_release_pc", pc_seen, 32'd4);

    // jump during stall with a valid instruction
    stall_v = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    jump_v = 1'b1; jt_v = 32'h0000_0203;
    cycle();
    jump_v = 1'b0;
    stall_v = 1'b0;
    cycle();
    check("stalljump_valid", {31'd0, if_valid}, 32'd0);
    check("stalljump_addr", mem_addr_o, 32'h0000_0200);
    run_until_new(8, pc_seen);
    check("stalljump_pc", pc_seen, 32'h0000_0200);

    // jump coinciding with the byte-2 ack
    do_reset();
    cycle();
    cycle();
    jump_v = 1'b1; jt_v = 32'h0000_0103; force_ack = 1'b1;
    cycle();
    jump_v = 1'b0; force_ack = 1'b0;
    cycle();
    check("jump_addr", mem_addr_o, 32'h0000_0100);
    check("jump_req", {31'd0, mem_req_o}, 32'd1);
    check("jump_valid", {31'd0, if_valid}, 32'd0);
    run_until_new(8, pc_seen);
    check("jump_pc", pc_seen, 32'h0000_0100);

    // PC wrap past the top of the address space
    jump_v = 1'b1; jt_v = 32'hFFFF_FFFE;
    cycle();
    jump_v = 1'b0;
    run_until_new(8, pc_seen);
    check("wrap_pc0", pc_seen, 32'hFFFF_FFFC);
    run_until_new(8, pc_seen);
    check("wrap_pc1", pc_seen, 32'h0000_0000);

    // random stalls, jumps and wait states
    do_reset();
    rand_wait = 1;
    ninst = 0;
    for (int i = 0; i < 1500; i++) begin
      stall_v = ($urandom_range(0, 9) < 3);
      jump_v  = ($urandom_range(0, 99) < 3);
      jt_v    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                            : 32'($urandom_range(0, 1023));
      cycle();
      if (new_inst) ninst++;
    end
    check("random_progress", {31'd0, ninst > 20}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage. Generates the PC and reads each 32-bit instruction as four byte reads over a byte-wide request/ack memory port. Assembles the bytes little-endian.
- Presents if_pc/if_inst to the IF/ID pipeline register.
- Obeys the IF stall bit from ctrl and the jump redirect from id. Holds one completed instruction while the pipeline is stalled.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset (bits [1:0] must be 0).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- stall  in  6  ctrl stall vector; bit `IF_BIT` (=1) is `Stop` (1) or `Continue` (0).
- jump_i  in  1  redirect request from id (`Jump`=1).
- jump_target_i  in  32  redirect address.
- mem_req_o  out  1  byte read request.
- mem_addr_o  out  32  byte address, valid while mem_req_o=1.
- mem_ack_i  in  1  read completed this cycle.
- mem_rdata_i  in  8  read byte, valid when mem_ack_i=1.
- if_pc  out  32  PC of the presented instruction; 0 when if_valid=0.
- if_inst  out  32  presented instruction; `ZeroWord` (bubble) when if_valid=0.
- if_valid  out  1  if_pc/if_inst hold a real instruction.

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC, byte_cnt=0, buf=0, state=FETCH.
  - if_pc=0, if_inst=0, if_valid=0.
  - Requests start in the first cycle after rst deasserts.
- Consume: the output slot is consumed on any rising edge with stall[`IF_BIT`]=0 and jump_i=0.
  - consume = if_valid & ~stall[IF] & ~jump_i.
  - slot_free = ~if_valid | consume.
- Memory protocol:
  - One outstanding byte at a time.
  - mem_addr_o = pc + byte_cnt.
  - The memory samples the address and returns data only in the ack cycle.
  - mem_req_o may be withdrawn or readdressed on any edge without an ack. The memory must not ack a withdrawn request.
  - Ack latency is arbitrary, including 0 extra cycles (ack in the same cycle as req).
- mem_req_o is combinational:
  - state==FETCH & ~jump_i & ~(byte_cnt==3 & ~slot_free).
  - The last byte is not requested until the output slot can accept the instruction.
- FETCH, ack with byte_cnt<3: buf[8*byte_cnt+:8] <= mem_rdata_i; byte_cnt++.
- FETCH, ack with byte_cnt==3 (slot_free guaranteed):
  - if_inst <= {mem_rdata_i, buf[23:0]}; if_pc <= pc; if_valid <= 1.
  - pc <= pc+4; byte_cnt <= 0.
  - The next fetch starts the following cycle (prefetch).
- FETCH, byte_cnt==3, slot full (stall): state <= BLOCK and mem_req_o=0. Bytes 0–2 are retained.
- BLOCK: when slot_free, return to FETCH and issue the byte-3 request.
- Consume without a new instruction completing that edge: if_valid <= 0, if_pc <= 0, if_inst <= 0.
- Latency: an instruction is presented 4 acks after its first request, so best case 4 cycles per instruction at 0-wait memory.
- jump_i=1 (highest priority below reset):
  - pc <= {jump_target_i[31:2],2'b00}; byte_cnt <= 0; buf <= 0; state <= FETCH.
  - if_valid <= 0, if_pc <= 0, if_inst <= 0.
  - A mem_ack_i in the same cycle is discarded.
  - Requests to the new pc start the next cycle.
- Jump while stalled: same as above; the jump overrides the stall.
- PC wraps modulo 2^32: 32'hFFFF_FFFC + 4 becomes 0.
- Reset mid-fetch: all fetch state is abandoned immediately; no request is issued while rst=0.

Decomposition:
- Shared defs package carries: `IF_BIT`, `Stop`/`Continue`, `Jump`, `ZeroWord`, `InstAddrBus`/`InstBus` widths, and the FETCH/BLOCK state encodings.
- Sub-module if_byte_asm: byte_cnt plus the 24-bit assembly buffer, with load/clear/complete outputs. The FSM, PC and output slot stay in if_fetch.

Test Plan:
- Reset then zero-wait memory with bytes 13,00,50,00 at addr 0 -> if_valid=1, if_inst=32'h0050_0013, if_pc=0 in cycle 5; next instruction at if_pc=4 in cycle 9.
- Memory acks after 2 wait cycles per byte -> each instruction is presented 12 cycles after its first request, and mem_addr_o stays stable between acks.
- stall[1]=1 for 10 cycles with an instruction held -> if_pc/if_inst unchanged; the next fetch stops at byte_cnt=3 with mem_req_o=0; after release, byte 3 is requested and the new instruction appears the edge after its ack.
- jump_i=1, target 32'h0000_0103, in the same cycle as the byte-2 ack -> ack discarded; outputs bubble; the next cycle mem_addr_o=32'h100; the next presented if_pc=32'h100.
- Jump during stall with if_valid=1 -> if_valid=0 the next cycle, and fetch restarts at the target.
- Assert rst=0 mid-fetch at pc=8 -> outputs 0 immediately (asynchronous); after release the first mem_addr_o=RESET_PC.
